// File: rtl/mux9_scan_pkg.sv
// Shared types and helpers for the 9:1 mux scan sequencer: channel count,
// FSM states and the channel-to-select encoding of the 8:1 + 2:1 mux tree.
package mux9_scan_pkg;

  localparam int NUM_CH = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } scan_state_t;

  localparam logic [3:0] SEL_IDLE = 4'b0000;

  // Channel 8 is reached through the 2:1 stage (s3); 0..7 go through the 8:1 stage.
  function automatic logic [3:0] chan_to_sel(input logic [3:0] idx);
    return (idx == 4'd8) ? 4'b1000 : {1'b0, idx[2:0]};
  endfunction

endpackage

// File: rtl/mux9_next_chan.sv
// Combinational search for the lowest enabled channel strictly above cur_idx,
// or the lowest enabled channel overall when first is set.
module mux9_next_chan
  import mux9_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [3:0]        cur_idx,
  input  logic              first,
  output logic [3:0]        nxt_idx,
  output logic              found
);

  // Descending scan so the lowest qualifying channel is the last one written.
  always_comb begin
    nxt_idx = 4'd0;
    found   = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (mask[c] && (first || (4'(c) > cur_idx))) begin
        nxt_idx = 4'(c);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux9_scan_sequencer.sv
// Scans enabled mux channels (SETTLE_CYCLES+1 cycles each) into a 9-bit frame with valid/ready output;
// frame held until accepted. Optional continuous rescan with overrun flag under MUX9_SCAN_CONTINUOUS_EN.
module mux9_scan_sequencer
  import mux9_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic              mux_in,
  output logic [3:0]        sel,
  output logic              busy,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid,
  input  logic              frame_ready
`ifdef MUX9_SCAN_CONTINUOUS_EN
  ,
  input  logic              continuous,
  output logic              overrun
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  scan_state_t       state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] frame_q, frame_d;
  logic              frame_valid_q, frame_valid_d;
  logic              overrun_q, overrun_d;
  logic [NUM_CH-1:0] shadow_fin;

  logic [3:0] next_idx, first_idx;
  logic       next_found, first_found;

  // Next channel within the latched mask, and first channel of a freshly latched mask.
  mux9_next_chan u_next (
    .mask    (mask_q),
    .cur_idx (idx_q),
    .first   (1'b0),
    .nxt_idx (next_idx),
    .found   (next_found)
  );

  mux9_next_chan u_first (
    .mask    (chan_mask),
    .cur_idx (4'd0),
    .first   (1'b1),
    .nxt_idx (first_idx),
    .found   (first_found)
  );

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    mask_d        = mask_q;
    shadow_d      = shadow_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q & ~frame_ready;
    overrun_d     = 1'b0;
    shadow_fin    = shadow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d   = chan_mask;
          shadow_d = '0;
          cnt_d    = '0;
          if (first_found) begin
            state_d = SETTLE;
            idx_d   = first_idx;
            sel_d   = chan_to_sel(first_idx);
          end else begin
            state_d       = HOLD;
            sel_d         = SEL_IDLE;
            frame_d       = '0;
            frame_valid_d = 1'b1;
          end
        end
      end

      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SAMPLE: begin
        shadow_fin[idx_q] = mux_in;
        shadow_d          = shadow_fin;
        if (next_found) begin
          state_d = SETTLE;
          idx_d   = next_idx;
          sel_d   = chan_to_sel(next_idx);
          cnt_d   = '0;
        end else begin
          // Frame complete: publish the shadow including this cycle's sample.
          frame_d       = shadow_fin;
          frame_valid_d = 1'b1;
          state_d       = HOLD;
          sel_d         = SEL_IDLE;
`ifdef MUX9_SCAN_CONTINUOUS_EN
          overrun_d = frame_valid_q & ~frame_ready;
          if (continuous) begin
            mask_d   = chan_mask;
            shadow_d = '0;
            cnt_d    = '0;
            if (first_found) begin
              state_d = SETTLE;
              idx_d   = first_idx;
              sel_d   = chan_to_sel(first_idx);
            end
          end
`endif
        end
      end

      HOLD: begin
        if (frame_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = SEL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= SEL_IDLE;
      cnt_q         <= '0;
      idx_q         <= 4'd0;
      mask_q        <= '0;
      shadow_q      <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      mask_q        <= mask_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign sel         = sel_q;
  assign busy        = (state_q != IDLE);
  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;

`ifdef MUX9_SCAN_CONTINUOUS_EN
  assign overrun = overrun_q;
`else
  logic unused_overrun;
  assign unused_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_mux9_scan_sequencer.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor pops and compares on each frame event.
module tb_mux9_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [8:0] chan_mask;
  logic       mux_in;
  logic [3:0] sel;
  logic       busy;
  logic [8:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic       continuous;
  logic       overrun;
  logic       mux_force;

  always #5 clk = ~clk;

  // Channel c returns c[0] (via sel[0]) unless forced to 1.
  assign mux_in = mux_force ? 1'b1 : sel[0];

  mux9_scan_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .chan_mask   (chan_mask),
    .mux_in      (mux_in),
    .sel         (sel),
    .busy        (busy),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
`ifdef MUX9_SCAN_CONTINUOUS_EN
    ,
    .continuous  (continuous),
    .overrun     (overrun)
`endif
  );

`ifndef MUX9_SCAN_CONTINUOUS_EN
  assign overrun = 1'b0;
`endif

  typedef struct {
    logic [8:0] frm;
    int         edge_n;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic fv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [3:0] exp_sel9(input int k);
    int ch;
    ch = k / 3;
    return (ch == 8) ? 4'b1000 : {1'b0, ch[2:0]};
  endfunction

  // Monitor: a frame event is a rising frame_valid or an overrun pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && ((frame_valid && !fv_prev) || overrun)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame_event", 32'(frame), 32'h1ff00);
      end else begin
        e = exp_q.pop_front();
        chk("frame_value", 32'(frame), 32'(e.frm));
        chk("frame_edge", cyc, e.edge_n);
        chk("overrun_at_event", 32'(overrun), 32'(e.ovr));
      end
    end
    fv_prev = frame_valid;
  end

  task automatic push_exp(input logic [8:0] f, input int edge_n, input logic o);
    exp_t e;
    e.frm = f; e.edge_n = edge_n; e.ovr = o;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge E0.
  task automatic issue_start(input logic [8:0] m, input logic [8:0] f);
    start     = 1'b1;
    chan_mask = m;
    push_exp(f, cyc + 1 + $countones(m) * 3, 1'b0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!frame_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!frame_valid) chk(name, 32'(frame_valid), 32'd1);
  endtask

  task automatic accept();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk("fv_after_accept", 32'(frame_valid), 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; chan_mask = '0; frame_ready = 1'b0;
    continuous = 1'b0; mux_force = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full mask, channel c returns c[0].
    issue_start(9'h1FF, 9'h0AA);
    for (int k = 0; k < 27; k++) begin
      chk($sformatf("sel_full_k%0d", k), 32'(sel), 32'(exp_sel9(k)));
      @(negedge clk);
    end
    chk("sel_after_full", 32'(sel), 32'd0);
    wait_valid("timeout_full");
    accept();
    chk("frame_kept", 32'(frame), 32'h0AA);

    // Channels 0 and 8 only, mux forced high; then hold off ready.
    mux_force = 1'b1;
    issue_start(9'h101, 9'h101);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("sel_pair_k%0d", k), 32'(sel), (k < 3) ? 32'h0 : 32'h8);
      @(negedge clk);
    end
    wait_valid("timeout_pair");
    for (int i = 0; i < 10; i++) begin
      start     = (i == 4);
      chan_mask = (i == 4) ? 9'h1FF : 9'h101;
      chk("hold_fv", 32'(frame_valid), 32'd1);
      chk("hold_frame", 32'(frame), 32'h101);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_sel", 32'(sel), 32'd0);
      @(negedge clk);
    end
    start = 1'b1;
    accept();
    start = 1'b0;
    @(negedge clk);
    chk("start_at_accept_ignored", 32'(busy), 32'd0);

    // Reset in the middle of channel 4, then a clean full scan.
    mux_force = 1'b0;
    issue_start(9'h1FF, 9'h0AA);
    repeat (13) @(negedge clk);
    chk("mid_sel_ch4", 32'(sel), 32'd4);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_frame", 32'(frame), 32'd0);
    chk("midrst_fv", 32'(frame_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    mux_force = 1'b1;
    issue_start(9'h1FF, 9'h1FF);
    wait_valid("timeout_after_rst");
    accept();

    // Empty mask: frame of zeros at the accepting edge, ready already high.
    chk("idle_busy_before_zero", 32'(busy), 32'd0);
    frame_ready = 1'b1;
    issue_start(9'h000, 9'h000);
    chk("zero_busy_hold", 32'(busy), 32'd1);
    chk("zero_fv", 32'(frame_valid), 32'd1);
    @(negedge clk);
    frame_ready = 1'b0;
    chk("zero_busy_after", 32'(busy), 32'd0);
    chk("zero_fv_after", 32'(frame_valid), 32'd0);

`ifdef MUX9_SCAN_CONTINUOUS_EN
    // Continuous: second frame (re-latched mask) overwrites the unaccepted first.
    begin
      int e0;
      mux_force  = 1'b0;
      continuous = 1'b1;
      start      = 1'b1;
      chan_mask  = 9'h003;
      e0 = cyc + 1;
      push_exp(9'h002, e0 + 6, 1'b0);
      push_exp(9'h00A, e0 + 12, 1'b1);
      @(negedge clk);
      start     = 1'b0;
      chan_mask = 9'h00A;
      repeat (7) @(negedge clk);
      continuous = 1'b0;
      repeat (5) @(negedge clk);
      chk("cont_edge12", cyc, e0 + 12);
      chk("cont_overrun_hi", 32'(overrun), 32'd1);
      @(negedge clk);
      chk("cont_overrun_pulse", 32'(overrun), 32'd0);
      chk("cont_frame_kept", 32'(frame), 32'h00A);
      accept();
    end
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
